// File: rtl/lbm_field_capture.sv
// Double-buffered capture of LBM macroscopic fields (u_x, u_y, rho, u^2) per node,
// with a 2-cycle pipelined random-access read port onto the last completed frame.
module lbm_field_capture #(
    parameter int unsigned DEPTH      = 2500,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_collision_state,
    input  logic                  collider_ready,
    input  logic [DATA_WIDTH-1:0] u_x,
    input  logic [DATA_WIDTH-1:0] u_y,
    input  logic [DATA_WIDTH-1:0] rho,
    input  logic [DATA_WIDTH-1:0] u_squared,
    input  logic                  hold,
    input  logic                  clr_flags,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_ux,
    output logic [DATA_WIDTH-1:0] rd_uy,
    output logic [DATA_WIDTH-1:0] rd_rho,
    output logic [DATA_WIDTH-1:0] rd_u2,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            drop_cnt,
    output logic                  short_frame,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned WORD_WIDTH = 4 * DATA_WIDTH;
    localparam int unsigned MEM_WORDS  = 2 ** (ADDR_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_NODE = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  coll_q;
    logic                  coll_rise;

    logic wr_en;
    logic ptr_clr;
    logic swap;
    logic set_short;
    logic set_overflow;
    logic inc_drop;

    logic [WORD_WIDTH-1:0] mem [0:MEM_WORDS-1];
    logic [WORD_WIDTH-1:0] rd_word;
    logic                  rd_s1_valid;
    logic                  rd_s1_in_range;

    assign coll_rise = in_collision_state & ~coll_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next   = state;
        wr_en        = 1'b0;
        ptr_clr      = 1'b0;
        swap         = 1'b0;
        set_short    = 1'b0;
        set_overflow = 1'b0;
        inc_drop     = 1'b0;
        case (state)
            ST_WAIT: begin
                set_overflow = collider_ready;
                if (coll_rise) begin
                    ptr_clr    = 1'b1;
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                wr_en = collider_ready;
                if (collider_ready && (wr_ptr == LAST_NODE)) begin
                    if (hold) begin
                        state_next = ST_PENDING;
                    end else begin
                        swap       = 1'b1;
                        state_next = ST_WAIT;
                    end
                end else if (!in_collision_state) begin
                    set_short  = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_PENDING: begin
                inc_drop = coll_rise;
                if (!hold) begin
                    swap       = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    // Bank control, write pointer and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q      <= 1'b0;
            wr_bank     <= 1'b1;
            rd_bank     <= 1'b0;
            wr_ptr      <= '0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            short_frame <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coll_q     <= in_collision_state;
            frame_done <= swap;
            busy       <= (state_next != ST_WAIT);

            if (ptr_clr) begin
                wr_ptr <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end

            if (swap) begin
                wr_bank   <= ~wr_bank;
                rd_bank   <= ~rd_bank;
                frame_cnt <= frame_cnt + 16'd1;
            end

            // A set event in the same cycle as a clear takes priority
            if (set_short) begin
                short_frame <= 1'b1;
            end else if (clr_flags) begin
                short_frame <= 1'b0;
            end

            if (set_overflow) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end

            if (inc_drop) begin
                if (clr_flags) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (clr_flags) begin
                drop_cnt <= '0;
            end
        end
    end

    // Snapshot memory: write to the capture bank, read from the host bank
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_ptr}] <= {u_x, u_y, rho, u_squared};
        end
        if (rd_req) begin
            rd_word <= mem[{rd_bank, rd_addr}];
        end
    end

    // Read pipeline; bank is bound to the request cycle via the memory address
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1_valid    <= 1'b0;
            rd_s1_in_range <= 1'b0;
            rd_valid       <= 1'b0;
            rd_ux          <= '0;
            rd_uy          <= '0;
            rd_rho         <= '0;
            rd_u2          <= '0;
        end else begin
            rd_s1_valid    <= rd_req;
            rd_s1_in_range <= (32'(rd_addr) < DEPTH);
            rd_valid       <= rd_s1_valid;
            if (rd_s1_valid) begin
                if (rd_s1_in_range) begin
                    {rd_ux, rd_uy, rd_rho, rd_u2} <= rd_word;
                end else begin
                    {rd_ux, rd_uy, rd_rho, rd_u2} <= '0;
                end
            end
        end
    end

endmodule
